// File: rtl/cbus_arbiter.sv
// Purpose: shares one CBus master port among NUM_INPUTS requesters and holds the grant for a whole burst.
// Latency: one cycle from a request to oreq_valid; one idle bubble between bursts; request path is muxed combinationally while granted.
// Backpressure: the owner's handshake is oresp_ready/oresp_last passed straight back; non-owners see ready=0 and wait.
//
// Ports:
//   clk, resetn                       clock, asynchronous active-low reset
//   ireq_*  (packed per requester)    valid, is_write, size, addr, strobe, data, len (beats-1)
//   iresp_* (packed per requester)    ready, last, data; only the owner sees non-zero values
//   oreq_*                            granted request forwarded downstream (all zero when idle)
//   oresp_ready, oresp_last, oresp_data  downstream beat handshake and read data
//   busy, grant_idx                   grant held, current owner (meaningful while busy)
//
// Build option: define CBUS_ARB_FIXED_PRIO_EN for lowest-index-wins priority
// instead of round-robin.
module cbus_arbiter #(
  parameter int NUM_INPUTS = 2,
  parameter int IDX_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NUM_INPUTS-1:0]   ireq_valid,
  input  logic [NUM_INPUTS-1:0]   ireq_is_write,
  input  logic [3*NUM_INPUTS-1:0] ireq_size,
  input  logic [32*NUM_INPUTS-1:0] ireq_addr,
  input  logic [4*NUM_INPUTS-1:0] ireq_strobe,
  input  logic [32*NUM_INPUTS-1:0] ireq_data,
  input  logic [4*NUM_INPUTS-1:0] ireq_len,
  output logic [NUM_INPUTS-1:0]   iresp_ready,
  output logic [NUM_INPUTS-1:0]   iresp_last,
  output logic [32*NUM_INPUTS-1:0] iresp_data,
  output logic                    oreq_valid,
  output logic                    oreq_is_write,
  output logic [2:0]              oreq_size,
  output logic [31:0]             oreq_addr,
  output logic [3:0]              oreq_strobe,
  output logic [31:0]             oreq_data,
  output logic [3:0]              oreq_len,
  input  logic                    oresp_ready,
  input  logic                    oresp_last,
  input  logic [31:0]             oresp_data,
  output logic                    busy,
  output logic [IDX_W-1:0]        grant_idx
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] grant_q;
  logic [IDX_W-1:0] winner;
  logic             burst_done;

  assign burst_done = (state_q == BUSY) && oresp_ready && oresp_last;

`ifdef CBUS_ARB_FIXED_PRIO_EN
  // Descending scan: the last write wins, so the lowest asserted index is kept.
  always_comb begin
    winner = '0;
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      if (ireq_valid[i]) winner = IDX_W'(i);
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] hi_win, lo_win;
  logic             hi_found;

  // Round-robin split into two halves: the lowest requester at or above
  // rr_ptr has priority; otherwise the scan wraps to the lowest below it.
  always_comb begin
    hi_win   = '0;
    lo_win   = '0;
    hi_found = 1'b0;
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      if (ireq_valid[i]) begin
        if (IDX_W'(i) >= rr_ptr_q) begin
          hi_win   = IDX_W'(i);
          hi_found = 1'b1;
        end else begin
          lo_win = IDX_W'(i);
        end
      end
    end
    winner = hi_found ? hi_win : lo_win;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr_q <= '0;
    end else if (burst_done) begin
      rr_ptr_q <= (grant_q == IDX_W'(NUM_INPUTS - 1)) ? '0 : grant_q + IDX_W'(1);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|ireq_valid) state_d = BUSY;
      BUSY:    if (oresp_ready && oresp_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      // Grant is captured only in IDLE, so requests raised mid-burst wait.
      if (state_q == IDLE && (|ireq_valid)) grant_q <= winner;
    end
  end

  // Everything downstream and back to requesters is gated by BUSY, so reset
  // forces all outputs to zero at once, and ireq_valid only reaches
  // oreq_valid through the registered state.
  always_comb begin
    oreq_valid    = 1'b0;
    oreq_is_write = 1'b0;
    oreq_size     = '0;
    oreq_addr     = '0;
    oreq_strobe   = '0;
    oreq_data     = '0;
    oreq_len      = '0;
    iresp_ready   = '0;
    iresp_last    = '0;
    iresp_data    = '0;
    if (state_q == BUSY) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (grant_q == IDX_W'(i)) begin
          oreq_valid             = ireq_valid[i];
          oreq_is_write          = ireq_is_write[i];
          oreq_size              = ireq_size[3*i +: 3];
          oreq_addr              = ireq_addr[32*i +: 32];
          oreq_strobe            = ireq_strobe[4*i +: 4];
          oreq_data              = ireq_data[32*i +: 32];
          oreq_len               = ireq_len[4*i +: 4];
          iresp_ready[i]         = oresp_ready;
          iresp_last[i]          = oresp_last;
          iresp_data[32*i +: 32] = oresp_data;
        end
      end
    end
  end

  assign busy      = (state_q == BUSY);
  assign grant_idx = grant_q;

endmodule
